// File: rtl/radiometer_pkg.sv
// radiometer_pkg: shared types and width helpers for the Dicke radiometer back end
package radiometer_pkg;

    typedef enum logic [1:0] {IDLE, SIG, REF} state_t;

    localparam int DEF_SAMPLE_W = 12;

    function automatic int cnt_width(input int half_period, input int n_cycles);
        return $clog2(half_period * n_cycles + 1);
    endfunction

    function automatic int acc_width(input int sample_w, input int half_period, input int n_cycles);
        return sample_w + cnt_width(half_period, n_cycles);
    endfunction

endpackage

// File: rtl/dicke_phase_timer.sv
// dicke_phase_timer: switch state machine with phase/period counters, blanking gate and frame-end flag
module dicke_phase_timer
    import radiometer_pkg::*;
#(
    parameter int HALF_PERIOD = 5000,
    parameter int BLANK       = 500,
    parameter int N_CYCLES    = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic switch_out,
    output logic adc_gate,
    output logic frame_end
);

    localparam int PH_W = $clog2(HALF_PERIOD);
    localparam int PER_W = $clog2(N_CYCLES + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PERIOD - 1);
    localparam logic [PH_W-1:0] GATE_PRE = PH_W'(BLANK - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(N_CYCLES - 1);

    state_t state;
    logic [PH_W-1:0] phase;
    logic [PER_W-1:0] period;

    assign frame_end = enable && state == REF && phase == PH_LAST && period == PER_LAST;

    // Walk IDLE -> SIG <-> REF; switch_out and adc_gate are registered from the next phase/state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            phase      <= '0;
            period     <= '0;
            switch_out <= 1'b0;
            adc_gate   <= 1'b0;
        end else if (!enable) begin
            state      <= IDLE;
            phase      <= '0;
            period     <= '0;
            switch_out <= 1'b0;
            adc_gate   <= 1'b0;
        end else if (state == IDLE) begin
            state      <= SIG;
            phase      <= '0;
            switch_out <= 1'b1;
            adc_gate   <= 1'b0;
        end else if (phase == PH_LAST) begin
            state      <= (state == SIG) ? REF : SIG;
            phase      <= '0;
            switch_out <= (state == REF);
            adc_gate   <= 1'b0;
            if (state == REF)
                period <= (period == PER_LAST) ? '0 : period + 1'b1;
        end else begin
            phase    <= phase + 1'b1;
            adc_gate <= (phase >= GATE_PRE);
        end
    end

endmodule

// File: rtl/dicke_sequencer.sv
// dicke_sequencer: Dicke switch drive, blanked signal/reference integration and per-frame result handshake
module dicke_sequencer
    import radiometer_pkg::*;
#(
    parameter int SAMPLE_W    = DEF_SAMPLE_W,
    parameter int HALF_PERIOD = 5000,
    parameter int BLANK       = 500,
    parameter int N_CYCLES    = 100,
    localparam int CNT_W      = cnt_width(HALF_PERIOD, N_CYCLES),
    localparam int ACC_W      = acc_width(SAMPLE_W, HALF_PERIOD, N_CYCLES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    adc_valid,
    input  logic [SAMPLE_W-1:0]     adc_data,
    output logic                    switch_out,
    output logic                    adc_gate,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [ACC_W:0]   res_diff,
    output logic [CNT_W-1:0]        res_n_sig,
    output logic [CNT_W-1:0]        res_n_ref,
    output logic                    overrun
);

    logic frame_end;
    logic take_sig, take_ref;
    logic [ACC_W-1:0] sum_sig, sum_ref, sig_nx, ref_nx;
    logic [CNT_W-1:0] n_sig, n_ref, n_sig_nx, n_ref_nx;

    dicke_phase_timer #(
        .HALF_PERIOD(HALF_PERIOD),
        .BLANK(BLANK),
        .N_CYCLES(N_CYCLES)
    ) u_timer (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .switch_out(switch_out),
        .adc_gate(adc_gate),
        .frame_end(frame_end)
    );

    assign take_sig = adc_valid && adc_gate && switch_out;
    assign take_ref = adc_valid && adc_gate && !switch_out;
    assign sig_nx   = sum_sig + (take_sig ? ACC_W'(adc_data) : '0);
    assign ref_nx   = sum_ref + (take_ref ? ACC_W'(adc_data) : '0);
    assign n_sig_nx = n_sig + CNT_W'(take_sig);
    assign n_ref_nx = n_ref + CNT_W'(take_ref);

    // Integrate accepted samples; frame end or a dropped enable restarts from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || frame_end || !enable) begin
            sum_sig <= '0;
            sum_ref <= '0;
            n_sig   <= '0;
            n_ref   <= '0;
        end else begin
            sum_sig <= sig_nx;
            sum_ref <= ref_nx;
            n_sig   <= n_sig_nx;
            n_ref   <= n_ref_nx;
        end
    end

    // Result register: load at frame end (including that cycle's sample), hold until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_diff  <= '0;
            res_n_sig <= '0;
            res_n_ref <= '0;
            overrun   <= 1'b0;
        end else if (frame_end) begin
            res_valid <= 1'b1;
            res_diff  <= $signed({1'b0, sig_nx}) - $signed({1'b0, ref_nx});
            res_n_sig <= n_sig_nx;
            res_n_ref <= n_ref_nx;
            overrun   <= overrun | (res_valid & ~res_ready);
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dicke_sequencer.sv
// tb_dicke_sequencer: directed scoreboard bench for dicke_sequencer (HALF_PERIOD=8, BLANK=2, N_CYCLES=2)
module tb_dicke_sequencer;

    localparam int CNT_W = 5;
    localparam int ACC_W = 17;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b1;
    logic res_ready = 1'b1;
    logic adc_valid;
    logic [11:0] adc_data;
    logic switch_out, adc_gate, res_valid, overrun;
    logic signed [ACC_W:0] res_diff;
    logic [CNT_W-1:0] res_n_sig, res_n_ref;

    typedef struct {
        longint diff;
        longint ns;
        longint nr;
        int     t;
    } exp_s;

    exp_s q[$];
    exp_s e;
    int tests = 0;
    int fails = 0;
    int run_t = 0;
    int p;
    int low;
    logic blank_mode = 1'b0;
    logic [11:0] sig0 = 12'd100, ref0 = 12'd40, sig1 = 12'd100, ref1 = 12'd40;

    dicke_sequencer #(
        .SAMPLE_W(12),
        .HALF_PERIOD(8),
        .BLANK(2),
        .N_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .adc_valid(adc_valid),
        .adc_data(adc_data),
        .switch_out(switch_out),
        .adc_gate(adc_gate),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_diff(res_diff),
        .res_n_sig(res_n_sig),
        .res_n_ref(res_n_ref),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Bench time base: run_t = 1 in the first SIG cycle after enable is sampled
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_t <= 0;
        else run_t <= enable ? run_t + 1 : 0;
    end

    // Sample source driven from the bench's own phase model
    always @* begin
        p = run_t - 1;
        adc_valid = blank_mode ? (run_t > 0 && p % 8 < 2) : 1'b1;
        adc_data = ((p / 8) % 2 == 0) ? ((p / 32 == 0) ? sig0 : sig1) : ((p / 32 == 0) ? ref0 : ref1);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input longint diff, input longint ns, input longint nr, input int t);
        exp_s x;
        x.diff = diff;
        x.ns = ns;
        x.nr = nr;
        x.t = t;
        q.push_back(x);
    endtask

    // Monitor: switch/gate waveform against the phase model, results against the scoreboard
    always @(negedge clk) begin
        chk("switch_out", switch_out, run_t > 0 && ((run_t - 1) / 8) % 2 == 0);
        chk("adc_gate", adc_gate, run_t > 0 && (run_t - 1) % 8 >= 2);
        if (res_valid && res_ready) begin
            chk("result_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("res_diff", res_diff, e.diff);
                chk("res_n_sig", res_n_sig, e.ns);
                chk("res_n_ref", res_n_ref, e.nr);
                if (e.t != 0) chk("res_time", run_t, e.t);
            end
        end
    end

    initial begin
        // reset held with enable high
        cycles(5);
        chk("rst_switch_out", switch_out, 0);
        chk("rst_adc_gate", adc_gate, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_res_diff", res_diff, 0);
        chk("rst_n_sig", res_n_sig, 0);
        chk("rst_n_ref", res_n_ref, 0);

        // basic frames: 12*100 - 12*40
        rst_n = 1'b1;
        push(720, 12, 12, 33);
        push(720, 12, 12, 65);
        cycles(66);
        chk("basic_drained", q.size(), 0);

        // blanking: samples only in phases 0-1
        enable = 1'b0;
        cycles(2);
        blank_mode = 1'b1;
        push(0, 0, 0, 33);
        enable = 1'b1;
        low = 0;
        for (int i = 0; i < 32; i++) begin
            cycles(1);
            low += int'(!adc_gate);
        end
        chk("gate_low_cycles", low, 8);
        cycles(2);
        chk("blank_drained", q.size(), 0);
        blank_mode = 1'b0;

        // backpressure: frame 1 100/40, frame 2 50/60, consumer stalled
        enable = 1'b0;
        res_ready = 1'b0;
        sig1 = 12'd50;
        ref1 = 12'd60;
        cycles(2);
        enable = 1'b1;
        cycles(40);
        chk("bp1_res_valid", res_valid, 1);
        chk("bp1_res_diff", res_diff, 720);
        chk("bp1_overrun", overrun, 0);
        cycles(26);
        chk("bp2_res_valid", res_valid, 1);
        chk("bp2_res_diff", res_diff, -120);
        chk("bp2_n_ref", res_n_ref, 12);
        chk("bp2_overrun", overrun, 1);
        push(-120, 12, 12, 0);
        res_ready = 1'b1;
        cycles(1);
        res_ready = 1'b0;
        chk("bp_valid_cleared", res_valid, 0);
        chk("bp_overrun_sticky", overrun, 1);
        chk("bp_drained", q.size(), 0);

        // enable drop at cycle 20, then full frame after re-enable
        enable = 1'b0;
        res_ready = 1'b1;
        sig1 = 12'd100;
        ref1 = 12'd40;
        cycles(2);
        enable = 1'b1;
        cycles(20);
        chk("drop_switch_before", switch_out, 1);
        enable = 1'b0;
        cycles(1);
        chk("drop_switch_after", switch_out, 0);
        cycles(10);
        chk("drop_no_result", res_valid, 0);
        chk("drop_overrun_kept", overrun, 1);
        push(720, 12, 12, 33);
        enable = 1'b1;
        cycles(34);
        chk("reenable_drained", q.size(), 0);

        // asynchronous reset mid-frame
        enable = 1'b0;
        cycles(2);
        enable = 1'b1;
        cycles(11);
        chk("pre_rst_gate", adc_gate, 1);
        chk("pre_rst_diff", res_diff, 720);
        rst_n = 1'b0;
        #1;
        chk("arst_adc_gate", adc_gate, 0);
        chk("arst_switch_out", switch_out, 0);
        chk("arst_overrun", overrun, 0);
        chk("arst_res_diff", res_diff, 0);
        chk("arst_n_sig", res_n_sig, 0);
        chk("arst_res_valid", res_valid, 0);
        cycles(2);
        rst_n = 1'b1;
        push(720, 12, 12, 33);
        cycles(34);
        chk("arst_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dicke_sequencer.md
# dicke_sequencer

Measurement sequencer for the 22 GHz Dicke-switched radiometer back end. It generates the switch drive and blanks ADC samples around every switch transition. It integrates the accepted samples separately for the signal (antenna) and reference (load) halves over a programmable number of switch periods. Each frame it emits one demodulated result (signal sum minus reference sum, plus sample counts) to the UART path over a valid/ready handshake. It sits between the ADC front end and `uart_toplevel`, and replaces the free-running `switching` PWM with a phase-aware source.

## Interface
- `SAMPLE_W`, 12: ADC sample width, unsigned.
- `HALF_PERIOD`, 5000: clock cycles per switch half-period, ≥ 4.
- `BLANK`, 500: cycles blanked at the start of each half, 1 ≤ BLANK < HALF_PERIOD.
- `N_CYCLES`, 100: full switch periods integrated per frame, ≥ 1.
- `CNT_W`, derived = clog2(HALF_PERIOD*N_CYCLES+1): width of a sample count.
- `ACC_W`, derived = SAMPLE_W + CNT_W: width of an accumulator.

Ports:
- `clk` in 1: 100 MHz system clock.
- `rst_n` in 1: asynchronous active-low reset; release is synchronous to `clk` at top level.
- `enable` in 1: run request, level.
- `adc_valid` in 1: one-cycle strobe, `adc_data` valid.
- `adc_data` in SAMPLE_W: unsigned ADC sample.
- `switch_out` out 1: Dicke switch drive; 1 = signal, 0 = reference.
- `adc_gate` out 1: 1 when samples are being accepted (outside blanking).
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts result.
- `res_diff` out ACC_W+1: signed sum_sig − sum_ref.
- `res_n_sig`, `res_n_ref` out CNT_W each: accepted sample counts.
- `overrun` out 1: sticky; a result was overwritten before acceptance.

## Operation
- States: IDLE, SIG, REF.
- IDLE → SIG when `enable` is 1. SIG → REF at phase = HALF_PERIOD−1. REF → SIG at phase = HALF_PERIOD−1. Any state → IDLE when `enable` is 0.
- Phase counter: 0..HALF_PERIOD−1, reset to 0 on every state change. Period counter: 0..N_CYCLES−1, incremented at the REF→SIG transition.
- `switch_out` = (state == SIG). `adc_gate` = (state != IDLE) && (phase ≥ BLANK).
- A sample is accepted when `adc_valid && adc_gate`. It is added to sum_sig/n_sig in SIG and to sum_ref/n_ref in REF. Additions are unsigned and cannot overflow by construction of ACC_W.
- Frame end is the last REF cycle of period N_CYCLES−1. That cycle's sample is included. On the next edge:
  - the result register loads the diff and counts, and `res_valid` is set;
  - the accumulators, counts, and period counter clear.
- The sample-accept path continues without a gap.
- Handshake: the result transfers on any cycle with `res_valid && res_ready`, and `res_valid` clears on the next edge. `res_*` are stable while `res_valid` is 1 and not accepted.
- Frame end while `res_valid` is 1 and not accepted this cycle: the new result overwrites the register, `res_valid` stays 1, and `overrun` sets. When frame end and acceptance coincide, the new result loads with no overrun.
- `enable` low: go to IDLE on the next edge and discard the partial frame (clear accumulators, counts, and counters). The pending result register and `overrun` are kept.
- `overrun` clears only on reset.

## Timing
- Reset: state IDLE. `switch_out`, `adc_gate`, `res_valid`, and `overrun` are 0. `res_diff` and the counts are 0.
- `enable` sampled 1 at edge k: SIG with phase 0 from cycle k+1, and `switch_out` is 1 in that cycle.
- Frame length: 2·HALF_PERIOD·N_CYCLES cycles.
- `res_valid` rises 1 cycle after the last REF cycle of the frame.
- All outputs are registered or decoded directly from registered state. There is no combinational path from `adc_*` or `res_ready` to any output.
- Reset asserted mid-frame: all state clears immediately, asynchronously.

## Structure
- Package `radiometer_pkg`:
  - state enum (IDLE/SIG/REF);
  - the CNT_W/ACC_W derivation function;
  - default widths for SAMPLE_W.
- One sub-module, `dicke_phase_timer`:
  - phase and period counters, state register, `enable` handling;
  - outputs `switch_out`, `adc_gate`, `frame_end`.
- The top level holds the accumulators, the result register, the handshake, and `overrun`.

## Test plan
Benches use HALF_PERIOD=8, BLANK=2, N_CYCLES=2, SAMPLE_W=12.
- Reset: hold `rst_n`=0 with `enable`=1 → all outputs 0, `switch_out` never toggles.
- Basic frame: `adc_valid`=1 continuously, data 100 when `switch_out`=1 and 40 otherwise, `res_ready`=1 → `res_valid` pulses 33 cycles after the `enable` edge. Result: `res_diff`=+720, `res_n_sig`=`res_n_ref`=12. Pattern repeats every 32 cycles.
- Blanking: `adc_valid` only in phases 0–1 → `res_diff`=0, counts 0, `adc_gate` low exactly 2 of every 8 cycles.
- Backpressure: `res_ready`=0 for two frames, with sig 50 / ref 60 in the second frame → `overrun`=1, `res_diff`=−120. Raising `res_ready` for 1 cycle clears `res_valid`; `overrun` stays 1.
- Enable drop: deassert `enable` at cycle 20 of a frame → `switch_out`=0 the next cycle, no `res_valid`. Re-enable → next result has full counts of 12 and 12.
- Async reset at cycle 10 mid-frame → outputs 0 in the same cycle, without waiting for a clock edge. After release plus `enable`, the first result matches the basic-frame values.
